// File: rtl/seven_segment_reader.sv
// Readback monitor for the multiplexed two-digit seven-segment bus: decodes
// samples, pairs unit/ten halves into frames and publishes a pair once it is stable.
module seven_segment_reader #(
   parameter int STABLE_FRAMES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] segments,
   input  logic       digit,
   input  logic       clear_error,
   output logic [3:0] ten_count,
   output logic [3:0] unit_count,
   output logic       valid,
   output logic       error
);
   localparam logic [3:0] MATCH_MAX = 4'(STABLE_FRAMES);

   typedef enum logic {
      WAIT_UNIT = 1'b0,
      WAIT_TEN  = 1'b1
   } state_t;

   state_t     r_state;
   logic [3:0] r_unit;
   logic [7:0] r_prev;
   logic [3:0] r_match;
   logic       r_published;

   logic [3:0] w_code;
   logic       w_frame;
   logic [7:0] w_cand;
   logic [3:0] w_match;
   logic       w_publish;
   logic       w_illegal;

   // Segment order is {g,f,e,d,c,b,a}; blank decodes to A, anything unknown to F.
   function automatic logic [3:0] decode(input logic [6:0] seg);
      logic [3:0] code;
      case (seg)
         7'b0111111: code = 4'h0;
         7'b0000110: code = 4'h1;
         7'b1011011: code = 4'h2;
         7'b1001111: code = 4'h3;
         7'b1100110: code = 4'h4;
         7'b1101101: code = 4'h5;
         7'b1111100: code = 4'h6;
         7'b0000111: code = 4'h7;
         7'b1111111: code = 4'h8;
         7'b1100111: code = 4'h9;
         7'b0000000: code = 4'hA;
         default:    code = 4'hF;
      endcase
      return code;
   endfunction

   always_comb begin
      w_code  = decode(segments);
      w_frame = (r_state == WAIT_TEN) && digit;
      w_cand  = {w_code, r_unit};
      // A zero match count means no frame seen since reset, so the first frame counts as 1.
      if (r_match == 4'd0 || w_cand != r_prev)
         w_match = 4'd1;
      else if (r_match >= MATCH_MAX)
         w_match = MATCH_MAX;
      else
         w_match = r_match + 4'd1;
      w_publish = w_frame && (w_match == MATCH_MAX) &&
                  (!r_published || w_cand != {ten_count, unit_count});
      w_illegal = (w_cand[7:4] == 4'hF) || (w_cand[3:0] == 4'hF);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= WAIT_UNIT;
         r_unit      <= 4'd0;
         r_prev      <= 8'd0;
         r_match     <= 4'd0;
         r_published <= 1'b0;
         ten_count   <= 4'd0;
         unit_count  <= 4'd0;
         valid       <= 1'b0;
         error       <= 1'b0;
      end else begin
         valid <= w_publish;
         case (r_state)
            WAIT_UNIT: begin
               if (!digit) begin
                  r_unit  <= w_code;
                  r_state <= WAIT_TEN;
               end
            end
            WAIT_TEN: begin
               // A held unit select keeps refreshing the unit half, so latest wins.
               if (!digit) begin
                  r_unit <= w_code;
               end else begin
                  r_state <= WAIT_UNIT;
                  r_prev  <= w_cand;
                  r_match <= w_match;
               end
            end
            default: r_state <= WAIT_UNIT;
         endcase
         if (w_publish) begin
            ten_count   <= w_cand[7:4];
            unit_count  <= w_cand[3:0];
            r_published <= 1'b1;
         end
         if (w_publish && w_illegal)
            error <= 1'b1;
         else if (clear_error)
            error <= 1'b0;
      end
   end
endmodule

// File: tb/tb_seven_segment_reader.sv
// Randomized and directed bench for seven_segment_reader against a frame-list reference model.
module tb_seven_segment_reader;
   localparam int N = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] segments;
   logic       digit;
   logic       clear_error;
   logic [3:0] ten_count;
   logic [3:0] unit_count;
   logic       valid;
   logic       error;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                            7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};

   // Reference state: pending unit half, run length of identical frames, published view.
   bit         m_have;
   logic [3:0] m_unit;
   logic [7:0] m_last;
   int         m_run;
   bit         m_pub;
   logic [3:0] m_ten_o, m_unit_o;
   bit         m_valid, m_err;

   seven_segment_reader #(.STABLE_FRAMES(N)) dut (
      .clk(clk), .reset(reset), .segments(segments), .digit(digit),
      .clear_error(clear_error), .ten_count(ten_count), .unit_count(unit_count),
      .valid(valid), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] ref_dec(input logic [6:0] s);
      for (int i = 0; i < 10; i++)
         if (pat[i] == s) return 4'(i);
      if (s == 7'd0) return 4'hA;
      return 4'hF;
   endfunction

   function automatic logic [6:0] seg_of(input int code);
      if (code < 10) return pat[code];
      if (code == 10) return 7'b0000000;
      if (code == 11) return 7'b1010101;
      return 7'($urandom);
   endfunction

   task automatic model(input logic [6:0] s, input logic d, input logic c, input logic r);
      logic [7:0] f;
      bit pub;
      pub = 0;
      if (r) begin
         m_have = 0; m_run = 0; m_pub = 0; m_last = 8'd0; m_unit = 4'd0;
         m_ten_o = 4'd0; m_unit_o = 4'd0; m_valid = 0; m_err = 0;
         return;
      end
      f = 8'd0;
      if (!d) begin
         m_unit = ref_dec(s);
         m_have = 1;
      end else if (m_have) begin
         f = {ref_dec(s), m_unit};
         m_have = 0;
         m_run = (m_run > 0 && f == m_last) ? m_run + 1 : 1;
         m_last = f;
         pub = (m_run >= N) && (!m_pub || f != {m_ten_o, m_unit_o});
         if (pub) begin
            m_ten_o = f[7:4]; m_unit_o = f[3:0]; m_pub = 1;
         end
      end
      m_valid = pub;
      if (pub && (f[7:4] == 4'hF || f[3:0] == 4'hF)) m_err = 1;
      else if (c) m_err = 0;
   endtask

   task automatic step(input logic [6:0] s, input logic d, input logic c, input logic r);
      segments = s; digit = d; clear_error = c; reset = r;
      @(posedge clk);
      model(s, d, c, r);
      #1;
      chk("ten_count", 32'(ten_count), 32'(m_ten_o));
      chk("unit_count", 32'(unit_count), 32'(m_unit_o));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("error", 32'(error), 32'(m_err));
   endtask

   task automatic frame(input int t, input int u, input logic c);
      step(seg_of(u), 1'b0, c, 1'b0);
      step(seg_of(t), 1'b1, c, 1'b0);
   endtask

   initial begin
      int vcount;
      int t, u, k;
      segments = 7'd0; digit = 1'b0; clear_error = 1'b0; reset = 1'b1;
      step(7'd0, 1'b0, 1'b0, 1'b1);
      step(7'd0, 1'b0, 1'b0, 1'b1);
      chk("reset_ten", 32'(ten_count), 32'd0);
      chk("reset_unit", 32'(unit_count), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_error", 32'(error), 32'd0);

      // "73": first publication on the 4th edge, then silence for 20 frames.
      frame(7, 3, 1'b0);
      chk("first_frame_no_valid", 32'(valid), 32'd0);
      frame(7, 3, 1'b0);
      chk("pub73_valid", 32'(valid), 32'd1);
      chk("pub73_ten", 32'(ten_count), 32'd7);
      chk("pub73_unit", 32'(unit_count), 32'd3);
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         frame(7, 3, 1'b0);
         vcount += valid;
      end
      chk("no_repulse_73", 32'(vcount), 32'd0);

      // "42" steady, one-frame glitch to "43", back to "42".
      for (int i = 0; i < 3; i++) frame(4, 2, 1'b0);
      chk("pub42_unit", 32'(unit_count), 32'd2);
      vcount = 0;
      frame(4, 3, 1'b0); vcount += valid;
      for (int i = 0; i < 3; i++) begin frame(4, 2, 1'b0); vcount += valid; end
      chk("glitch_no_valid", 32'(vcount), 32'd0);
      chk("glitch_unit", 32'(unit_count), 32'd2);

      // Held unit select while unit changes 2 -> 5, then "45".
      step(pat[2], 1'b0, 1'b0, 1'b0);
      step(pat[5], 1'b0, 1'b0, 1'b0);
      frame(4, 5, 1'b0);
      frame(4, 5, 1'b0);
      chk("held_pub45_valid", 32'(valid), 32'd1);
      chk("held_pub45_unit", 32'(unit_count), 32'd5);

      // Illegal ten pattern, clear while stable, then clear coincident with a new illegal publish.
      frame(11, 1, 1'b0);
      frame(11, 1, 1'b0);
      chk("illegal_ten", 32'(ten_count), 32'hF);
      chk("illegal_err", 32'(error), 32'd1);
      frame(11, 1, 1'b1);
      frame(11, 1, 1'b0);
      chk("cleared_err", 32'(error), 32'd0);
      frame(11, 2, 1'b1);
      frame(11, 2, 1'b1);
      chk("set_wins_err", 32'(error), 32'd1);
      step(pat[0], 1'b0, 1'b1, 1'b0);

      // Blank on both digits is not an error.
      frame(10, 10, 1'b0);
      frame(10, 10, 1'b0);
      chk("blank_ten", 32'(ten_count), 32'hA);
      chk("blank_err", 32'(error), 32'd0);

      // Reset after the first "99" frame; "99" must publish afresh.
      frame(9, 9, 1'b0);
      step(pat[9], 1'b0, 1'b0, 1'b1);
      chk("rst_mid_ten", 32'(ten_count), 32'd0);
      frame(9, 9, 1'b0);
      frame(9, 9, 1'b0);
      chk("pub99_valid", 32'(valid), 32'd1);
      chk("pub99_ten", 32'(ten_count), 32'd9);

      // Randomized traffic: held values, held selects, stray ten samples, clears and resets.
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 99);
         if (k < 3) begin
            step(7'($urandom), 1'($urandom), 1'b0, 1'b1);
         end else if (k < 10) begin
            step(7'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
         end else begin
            t = $urandom_range(0, 12);
            u = $urandom_range(0, 12);
            for (int j = 0; j < $urandom_range(1, 4); j++)
               frame(t, u, 1'($urandom_range(0, 9) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
